// File: rtl/mult_div_pkg.sv
// Purpose : shared widths, state encoding and operand helpers for the mult/div units.
// Latency : n/a (package only).
// Backpressure : n/a.
package mult_div_pkg;

    localparam int A_W   = 32;  // dividend / quotient width
    localparam int B_W   = 16;  // divisor width
    localparam int ITER  = 32;  // one quotient bit per iteration
    localparam int CNT_W = 5;   // holds 0..ITER-1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [A_W-1:0] INT_MIN      = 32'h8000_0000;
    localparam logic [B_W-1:0] DIV_ALL_ONES = 16'hFFFF;

    // Magnitude of a signed dividend as 32-bit unsigned; INT_MIN maps to 0x80000000.
    function automatic logic [A_W-1:0] abs_a(input logic [A_W-1:0] a);
        return a[A_W-1] ? (~a + 1'b1) : a;
    endfunction

    // Magnitude of a signed divisor, widened to 17 bits so 0x8000 maps to 32768.
    function automatic logic [B_W:0] abs_b(input logic [B_W-1:0] b);
        logic [B_W:0] bx;
        bx = {b[B_W-1], b};
        return b[B_W-1] ? (~bx + 1'b1) : bx;
    endfunction

endpackage

// File: rtl/div_step.sv
// Purpose : one combinational restoring-division step (shift in dividend MSB, trial subtract).
// Latency : combinational.
// Backpressure : none; evaluated every cycle, used only while the divider is running.
// Ports   : rem (33b partial remainder), msb (next dividend bit), divisor (33b, zero-extended)
//           -> rem_next (updated remainder), q_bit (quotient bit produced by this step).
module div_step
    import mult_div_pkg::*;
(
    input  logic [A_W:0] rem,
    input  logic         msb,
    input  logic [A_W:0] divisor,
    output logic [A_W:0] rem_next,
    output logic         q_bit
);

    logic [A_W+1:0] shifted;
    logic [A_W+1:0] trial;

    // One extra bit on top so the sign of the trial subtraction is never lost.
    assign shifted  = {rem, msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[A_W+1];
    assign rem_next = q_bit ? trial[A_W:0] : shifted[A_W:0];

endmodule

// File: rtl/div_module.sv
// Purpose : sequential signed divider, 32b / 16b, restoring, one quotient bit per cycle.
// Latency : 34 cycles accept-to-resultRDY for normal ops, 1 cycle for divide-by-zero/overflow.
// Backpressure : data_inputRDY is high only in IDLE; ctrl_DIV is ignored while busy.
// Ports   : clock, reset (sync, active-high), ctrl_DIV start pulse, data_operandA dividend,
//           data_operandB divisor -> data_result quotient, data_exception, data_inputRDY,
//           data_resultRDY (one-cycle registered pulse).
module div_module
    import mult_div_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           ctrl_DIV,
    input  logic [A_W-1:0] data_operandA,
    input  logic [B_W-1:0] data_operandB,
    output logic [A_W-1:0] data_result,
    output logic           data_exception,
    output logic           data_inputRDY,
    output logic           data_resultRDY
);

    state_t           state;
    logic [A_W:0]     rem;
    logic [A_W-1:0]   dq;       // dividend shifts out the top while quotient bits shift in
    logic [A_W-1:0]   divisor;
    logic [CNT_W-1:0] count;
    logic             sign_q;

    logic [A_W:0]     rem_next;
    logic             q_bit;
    logic             is_exc;

    assign is_exc = (data_operandB == '0) ||
                    ((data_operandA == INT_MIN) && (data_operandB == DIV_ALL_ONES));

    assign data_inputRDY = (state == IDLE);

    div_step u_step (
        .rem      (rem),
        .msb      (dq[A_W-1]),
        .divisor  ({1'b0, divisor}),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            rem            <= '0;
            dq             <= '0;
            divisor        <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_DIV) begin
                        if (is_exc) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end else begin
                            sign_q  <= data_operandA[A_W-1] ^ data_operandB[B_W-1];
                            dq      <= abs_a(data_operandA);
                            divisor <= {{(A_W-B_W-1){1'b0}}, abs_b(data_operandB)};
                            rem     <= '0;
                            count   <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    dq    <= {dq[A_W-2:0], q_bit};
                    count <= count + 1'b1;
                    if (count == CNT_W'(ITER-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Magnitude quotient always fits once overflow is excluded, so
                    // negation here cannot wrap.
                    data_result    <= sign_q ? (~dq + 1'b1) : dq;
                    data_exception <= 1'b0;
                    data_resultRDY <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_module.sv
// Purpose : self-checking bench for div_module (directed cases plus randomized reference check).
// Latency : n/a.
// Backpressure : n/a.
module tb_div_module;
    import mult_div_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_inputRDY;
    logic        data_resultRDY;

    int errors     = 0;
    int checks     = 0;
    int rdy_pulses = 0;
    int accepted   = 0;

    div_module dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (a),
        .data_operandB  (b),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_inputRDY  (data_inputRDY),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) rdy_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division, exception on zero divisor or INT_MIN / -1.
    function automatic void ref_div(input logic [31:0] opa, input logic [15:0] opb,
                                    output logic [31:0] q, output logic e);
        int sa;
        int sb;
        sa = opa;
        sb = $signed(opb);
        if (sb == 0 || (opa == 32'h8000_0000 && sb == -1)) begin
            q = 32'd0;
            e = 1'b1;
        end else begin
            q = sa / sb;
            e = 1'b0;
        end
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // first IDLE cycle after the result pulse.
    task automatic do_op(input logic [31:0] opa, input logic [15:0] opb, input bit hold,
                         output logic [31:0] res, output logic exc, output int lat,
                         output int busy_bad);
        ctrl_DIV = 1'b1;
        a = opa;
        b = opb;
        @(negedge clock);
        accepted++;
        if (!hold) ctrl_DIV = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (data_resultRDY !== 1'b1 && lat < 100) begin
            if (data_inputRDY !== 1'b0) busy_bad++;
            if (hold) begin
                a = $urandom;
                b = 16'($urandom);
            end
            @(negedge clock);
            lat++;
        end
        ctrl_DIV = 1'b0;
        res = data_result;
        exc = data_exception;
        if (data_inputRDY !== 1'b0) busy_bad++;
        @(negedge clock);
        check("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
        check("idle_after_done", {31'd0, data_inputRDY}, 32'd1);
    endtask

    task automatic directed(input string tag, input logic [31:0] opa, input logic [15:0] opb,
                            input bit hold, input logic [31:0] exp_q, input logic exp_e,
                            input int exp_lat);
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          busy_bad;
        do_op(opa, opb, hold, res, exc, lat, busy_bad);
        check({tag, "_q"}, res, exp_q);
        check({tag, "_exc"}, {31'd0, exc}, {31'd0, exp_e});
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        logic [31:0] eq;
        logic        ee;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          busy_bad;
        int          sel;
        int          p0;

        reset    = 1'b1;
        ctrl_DIV = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clock);
        check("rst_inputRDY", {31'd0, data_inputRDY}, 32'd1);
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_resultRDY", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        directed("p100_p7", 32'd100, 16'd7, 1'b0, 32'd14, 1'b0, 34);
        directed("m100_p7", -32'sd100, 16'd7, 1'b0, 32'hFFFF_FFF2, 1'b0, 34);
        directed("p100_m7", 32'd100, -16'sd7, 1'b0, 32'hFFFF_FFF2, 1'b0, 34);
        directed("m100_m7", -32'sd100, -16'sd7, 1'b0, 32'd14, 1'b0, 34);
        directed("max_m32768", 32'h7FFF_FFFF, 16'h8000, 1'b0, 32'hFFFF_0001, 1'b0, 34);
        directed("div_zero", 32'd1234, 16'd0, 1'b0, 32'd0, 1'b1, 1);
        directed("overflow", 32'h8000_0000, 16'hFFFF, 1'b0, 32'd0, 1'b1, 1);
        directed("hold_45_4", 32'd45, 16'd4, 1'b1, 32'd11, 1'b0, 34);
        directed("next_9_3", 32'd9, 16'd3, 1'b0, 32'd3, 1'b0, 34);

        // Abort 1000 / 3 with a reset partway through.
        ctrl_DIV = 1'b1;
        a = 32'd1000;
        b = 16'd3;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_inputRDY", {31'd0, data_inputRDY}, 32'd1);
        check("abort_result", data_result, 32'd0);
        check("abort_exc", {31'd0, data_exception}, 32'd0);
        check("abort_resultRDY", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        p0 = rdy_pulses;
        repeat (40) @(negedge clock);
        check("abort_no_pulse", 32'(rdy_pulses), 32'(p0));
        directed("after_abort", 32'd1000, 16'd3, 1'b0, 32'd333, 1'b0, 34);

        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 15);
            ra  = $urandom;
            rb  = 16'($urandom);
            case (sel)
                0: rb = 16'd0;
                1: begin ra = 32'h8000_0000; rb = 16'hFFFF; end
                2: ra = 32'h8000_0000;
                3: rb = 16'h8000;
                4: rb = 16'($urandom_range(1, 15));
                5: rb = 16'hFFFF;
                6: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            ref_div(ra, rb, eq, ee);
            do_op(ra, rb, 1'b0, res, exc, lat, busy_bad);
            check($sformatf("rand%0d_q", i), res, eq);
            check($sformatf("rand%0d_exc", i), {31'd0, exc}, {31'd0, ee});
            check($sformatf("rand%0d_lat", i), 32'(lat), ee ? 32'd1 : 32'd34);
            check($sformatf("rand%0d_busy", i), 32'(busy_bad), 32'd0);
        end

        check("rdy_count", 32'(rdy_pulses), 32'(accepted));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
